// File: rtl/cnn_pkg.sv
// Shared types and the constant LeNet-5 layer table used by the layer sequencer.
package cnn_pkg;

   // Operation the compute engine performs for one layer.
   typedef enum logic [1:0] {
      OP_CONV = 2'd0,
      OP_POOL = 2'd1,
      OP_FC   = 2'd2
   } op_e;

   // Sequencer states.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_FIRE = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_e;

   // One row of the layer table.
   // w_off is a byte offset into weight memory.
   typedef struct packed {
      op_e         op;
      logic [5:0]  in_dim;
      logic [4:0]  in_ch;
      logic [6:0]  out_ch;
      logic [2:0]  k;
      logic        relu;
      logic [31:0] w_off;
   } layer_cfg_t;

   // LeNet-5 layers 0..4. Rows 5..7 are unused padding.
   // The FC layer is expressed as a 5x5 kernel covering the whole 5x5 input map.
   // Pooling rows keep the channel count and carry no weights.
   localparam layer_cfg_t LAYER_TABLE [0:7] = '{
      '{OP_CONV, 6'd32, 5'd1,  7'd6,   3'd5, 1'b1, 32'h0000_0000},
      '{OP_POOL, 6'd28, 5'd6,  7'd6,   3'd2, 1'b0, 32'h0000_0000},
      '{OP_CONV, 6'd14, 5'd6,  7'd16,  3'd5, 1'b1, 32'h0000_0260},
      '{OP_POOL, 6'd10, 5'd16, 7'd16,  3'd2, 1'b0, 32'h0000_0000},
      '{OP_FC,   6'd5,  5'd16, 7'd120, 3'd5, 1'b0, 32'h0000_2840},
      '{OP_CONV, 6'd0,  5'd0,  7'd0,   3'd0, 1'b0, 32'h0000_0000},
      '{OP_CONV, 6'd0,  5'd0,  7'd0,   3'd0, 1'b0, 32'h0000_0000},
      '{OP_CONV, 6'd0,  5'd0,  7'd0,   3'd0, 1'b0, 32'h0000_0000}
   };

   // Activation region written by layer idx.
   // Even layers write region A (base 0); odd layers write region B.
   function automatic logic [31:0] act_base(input logic [2:0] idx, input logic [31:0] b_base);
      return idx[0] ? b_base : 32'h0000_0000;
   endfunction

endpackage

// File: rtl/cnn_layer_seq.sv
// LeNet-5 layer sequencer.
// For each layer it loads the configuration from the constant table, pulses the
// compute engine and waits for completion. Activations ping-pong between two
// regions of TEMP BRAM. A per-layer timeout turns a silent engine into an error.
module cnn_layer_seq
   import cnn_pkg::*;
#(
   parameter int          NUM_LAYERS  = 5,
   parameter logic [31:0] TEMP_B_BASE = 32'h0000_1000,
   parameter int          TIMEOUT_CYC = 1 << 20
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic [2:0]  layer_idx,
   output logic        eng_start,
   input  logic        eng_done,
   output logic [1:0]  cfg_op,
   output logic        cfg_in_sel,
   output logic [31:0] cfg_in_base,
   output logic [31:0] cfg_out_base,
   output logic [31:0] cfg_w_base,
   output logic [5:0]  cfg_in_dim,
   output logic [4:0]  cfg_in_ch,
   output logic [6:0]  cfg_out_ch,
   output logic [2:0]  cfg_k,
   output logic        cfg_relu
);

   localparam int             CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [2:0]     LAST_IDX = 3'(NUM_LAYERS - 1);

   state_e           r_state;
   state_e           w_next;
   logic [2:0]       r_layer_idx;
   logic [CNT_W-1:0] r_cnt;

   logic [1:0]  r_cfg_op;
   logic        r_cfg_in_sel;
   logic [31:0] r_cfg_in_base;
   logic [31:0] r_cfg_out_base;
   logic [31:0] r_cfg_w_base;
   logic [5:0]  r_cfg_in_dim;
   logic [4:0]  r_cfg_in_ch;
   logic [6:0]  r_cfg_out_ch;
   logic [2:0]  r_cfg_k;
   logic        r_cfg_relu;

   layer_cfg_t  w_entry;
   logic        w_last;
   logic        w_limit;

   assign w_entry = LAYER_TABLE[r_layer_idx];
   assign w_last  = (r_layer_idx == LAST_IDX);
   assign w_limit = (r_cnt == CNT_LAST);

   // State register.
   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   // On the last timeout cycle eng_done wins over the timeout.
   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LOAD;
         S_LOAD:                w_next = S_FIRE;
         S_FIRE:                w_next = S_WAIT;
         S_WAIT: begin
            if (eng_done)     w_next = w_last ? S_DONE : S_LOAD;
            else if (w_limit) w_next = S_ERR;
         end
         default:               w_next = S_IDLE;
      endcase
   end

   // Handshake and status outputs, decoded from the state register.
   always_comb begin
      busy      = 1'b0;
      eng_start = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (r_state)
         S_LOAD, S_WAIT: busy = 1'b1;
         S_FIRE: begin
            busy      = 1'b1;
            eng_start = 1'b1;
         end
         S_DONE: done = 1'b1;
         S_ERR: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

   // Layer index, cfg registers and timeout counter.
   // cfg is only written in LOAD, so it holds through WAIT and into DONE/ERR.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_layer_idx    <= '0;
         r_cnt          <= '0;
         r_cfg_op       <= '0;
         r_cfg_in_sel   <= 1'b0;
         r_cfg_in_base  <= '0;
         r_cfg_out_base <= '0;
         r_cfg_w_base   <= '0;
         r_cfg_in_dim   <= '0;
         r_cfg_in_ch    <= '0;
         r_cfg_out_ch   <= '0;
         r_cfg_k        <= '0;
         r_cfg_relu     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) r_layer_idx <= '0;
            end
            S_LOAD: begin
               r_cfg_op       <= w_entry.op;
               r_cfg_in_sel   <= (r_layer_idx != 3'd0);
               r_cfg_in_base  <= (r_layer_idx == 3'd0) ? 32'h0
                                 : act_base(r_layer_idx - 3'd1, TEMP_B_BASE);
               r_cfg_out_base <= act_base(r_layer_idx, TEMP_B_BASE);
               r_cfg_w_base   <= w_entry.w_off;
               r_cfg_in_dim   <= w_entry.in_dim;
               r_cfg_in_ch    <= w_entry.in_ch;
               r_cfg_out_ch   <= w_entry.out_ch;
               r_cfg_k        <= w_entry.k;
               r_cfg_relu     <= w_entry.relu;
            end
            S_FIRE: r_cnt <= '0;
            S_WAIT: begin
               if (eng_done && !w_last) r_layer_idx <= r_layer_idx + 3'd1;
               // Saturate rather than wrap.
               if (!w_limit) r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign layer_idx    = r_layer_idx;
   assign cfg_op       = r_cfg_op;
   assign cfg_in_sel   = r_cfg_in_sel;
   assign cfg_in_base  = r_cfg_in_base;
   assign cfg_out_base = r_cfg_out_base;
   assign cfg_w_base   = r_cfg_w_base;
   assign cfg_in_dim   = r_cfg_in_dim;
   assign cfg_in_ch    = r_cfg_in_ch;
   assign cfg_out_ch   = r_cfg_out_ch;
   assign cfg_k        = r_cfg_k;
   assign cfg_relu     = r_cfg_relu;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for cnn_layer_seq.
// Instance A uses TIMEOUT_CYC=64 and is driven through full runs, restarts,
// start-while-busy, mid-run reset and a timeout. Instance B uses TIMEOUT_CYC=16
// for the done-on-last-timeout-cycle corner.
module tb_cnn_layer_seq;
   import cnn_pkg::*;

   localparam int TO_A = 64;
   localparam int TO_B = 16;

   logic clk;
   logic rst;

   logic        a_start, a_eng_done;
   logic        a_done, a_err, a_busy, a_eng_start;
   logic [2:0]  a_layer_idx;
   logic [1:0]  a_cfg_op;
   logic        a_cfg_in_sel;
   logic [31:0] a_cfg_in_base, a_cfg_out_base, a_cfg_w_base;
   logic [5:0]  a_cfg_in_dim;
   logic [4:0]  a_cfg_in_ch;
   logic [6:0]  a_cfg_out_ch;
   logic [2:0]  a_cfg_k;
   logic        a_cfg_relu;

   logic        b_start, b_eng_done;
   logic        b_done, b_err, b_busy, b_eng_start;
   logic [2:0]  b_layer_idx;
   logic [1:0]  b_cfg_op;
   logic        b_cfg_in_sel;
   logic [31:0] b_cfg_in_base, b_cfg_out_base, b_cfg_w_base;
   logic [5:0]  b_cfg_in_dim;
   logic [4:0]  b_cfg_in_ch;
   logic [6:0]  b_cfg_out_ch;
   logic [2:0]  b_cfg_k;
   logic        b_cfg_relu;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int a_pulses = 0;

   // Hand-written expectations per layer.
   int          exp_op [5] = '{0, 1, 0, 1, 2};
   logic [31:0] exp_w  [5] = '{32'h0, 32'h0, 32'h260, 32'h0, 32'h2840};
   logic [21:0] exp_shape [5] = '{
      {6'd32, 5'd1,  7'd6,   3'd5, 1'b1},
      {6'd28, 5'd6,  7'd6,   3'd2, 1'b0},
      {6'd14, 5'd6,  7'd16,  3'd5, 1'b1},
      {6'd10, 5'd16, 7'd16,  3'd2, 1'b0},
      {6'd5,  5'd16, 7'd120, 3'd5, 1'b0}
   };

   cnn_layer_seq #(.NUM_LAYERS(5), .TEMP_B_BASE(32'h0000_1000), .TIMEOUT_CYC(TO_A)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .done(a_done), .err(a_err), .busy(a_busy),
      .layer_idx(a_layer_idx), .eng_start(a_eng_start), .eng_done(a_eng_done),
      .cfg_op(a_cfg_op), .cfg_in_sel(a_cfg_in_sel), .cfg_in_base(a_cfg_in_base),
      .cfg_out_base(a_cfg_out_base), .cfg_w_base(a_cfg_w_base), .cfg_in_dim(a_cfg_in_dim),
      .cfg_in_ch(a_cfg_in_ch), .cfg_out_ch(a_cfg_out_ch), .cfg_k(a_cfg_k), .cfg_relu(a_cfg_relu)
   );

   cnn_layer_seq #(.NUM_LAYERS(5), .TEMP_B_BASE(32'h0000_1000), .TIMEOUT_CYC(TO_B)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .done(b_done), .err(b_err), .busy(b_busy),
      .layer_idx(b_layer_idx), .eng_start(b_eng_start), .eng_done(b_eng_done),
      .cfg_op(b_cfg_op), .cfg_in_sel(b_cfg_in_sel), .cfg_in_base(b_cfg_in_base),
      .cfg_out_base(b_cfg_out_base), .cfg_w_base(b_cfg_w_base), .cfg_in_dim(b_cfg_in_dim),
      .cfg_in_ch(b_cfg_in_ch), .cfg_out_ch(b_cfg_out_ch), .cfg_k(b_cfg_k), .cfg_relu(b_cfg_relu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count engine start pulses on the falling edge, away from state updates.
   always @(negedge clk) if (a_eng_start === 1'b1) a_pulses++;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One run on instance A with a 10-cycle engine model.
   // stray: eng_done also pulsed during the FIRE cycle of every layer.
   // poke_layer: start pulsed 3 cycles into WAIT of that layer.
   // hang_layer: engine never answers on that layer.
   // rst_layer: rst asserted 3 cycles into WAIT of that layer.
   task automatic run_a(input bit stray, input int poke_layer, input int hang_layer,
                        input int rst_layer);
      int c0, s_prev, n, p0;
      bit stop;
      p0 = a_pulses;
      c0 = cyc;
      s_prev = 0;
      stop = 1'b0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("start_clears_done", 32'(a_done), 0);
      check("start_clears_err", 32'(a_err), 0);
      check("start_sets_busy", 32'(a_busy), 1);
      for (int i = 0; i < 5 && !stop; i++) begin
         n = 0;
         while (a_eng_start !== 1'b1 && n < 25) begin
            tick();
            n++;
         end
         check($sformatf("eng_start_seen[%0d]", i), 32'(a_eng_start), 1);
         if (i == 0) check("first_fire_latency", cyc - c0, 2);
         else        check($sformatf("fire_period[%0d]", i), cyc - s_prev, 12);
         s_prev = cyc;
         check($sformatf("layer_idx[%0d]", i), 32'(a_layer_idx), i);
         check($sformatf("cfg_op[%0d]", i), 32'(a_cfg_op), exp_op[i]);
         check($sformatf("cfg_out_base[%0d]", i), a_cfg_out_base, (i % 2 == 1) ? 32'h1000 : 32'h0);
         check($sformatf("cfg_in_sel[%0d]", i), 32'(a_cfg_in_sel), (i == 0) ? 0 : 1);
         check($sformatf("cfg_in_base[%0d]", i), a_cfg_in_base,
               (i == 0) ? 32'h0 : ((i % 2 == 1) ? 32'h0 : 32'h1000));
         check($sformatf("cfg_w_base[%0d]", i), a_cfg_w_base, exp_w[i]);
         check($sformatf("cfg_shape[%0d]", i),
               32'({a_cfg_in_dim, a_cfg_in_ch, a_cfg_out_ch, a_cfg_k, a_cfg_relu}), 32'(exp_shape[i]));
         if (i == hang_layer) begin
            // WAIT lasts TO_A cycles after the FIRE cycle, so ERR shows TO_A+1 edges on.
            n = 0;
            while (a_done !== 1'b1 && n < 200) begin
               tick();
               n++;
            end
            check("timeout_latency", n, TO_A + 1);
            check("timeout_done", 32'(a_done), 1);
            check("timeout_err", 32'(a_err), 1);
            check("timeout_busy", 32'(a_busy), 0);
            check("timeout_layer_idx", 32'(a_layer_idx), i);
            check("timeout_pulses", a_pulses - p0, i + 1);
            stop = 1'b1;
         end else begin
            for (int k = 0; k < 10 && !stop; k++) begin
               a_eng_done = stray && (k == 0);
               a_start    = (k == 3) && (i == poke_layer);
               if ((k == 3) && (i == rst_layer)) begin
                  rst = 1'b1;
                  tick();
                  rst = 1'b0;
                  a_start = 1'b0;
                  check("rst_done", 32'(a_done), 0);
                  check("rst_err", 32'(a_err), 0);
                  check("rst_busy", 32'(a_busy), 0);
                  check("rst_eng_start", 32'(a_eng_start), 0);
                  check("rst_layer_idx", 32'(a_layer_idx), 0);
                  check("rst_cfg_bases", a_cfg_in_base | a_cfg_out_base | a_cfg_w_base, 0);
                  check("rst_cfg_misc",
                        32'({a_cfg_op, a_cfg_in_sel, a_cfg_in_dim, a_cfg_in_ch, a_cfg_out_ch,
                             a_cfg_k, a_cfg_relu}), 0);
                  check("rst_state", 32'(u_a.r_state), 32'(S_IDLE));
                  tick();
                  check("post_rst_eng_start", 32'(a_eng_start), 0);
                  check("post_rst_busy", 32'(a_busy), 0);
                  stop = 1'b1;
               end else begin
                  tick();
               end
            end
            a_eng_done = 1'b0;
            a_start    = 1'b0;
            if (!stop) begin
               a_eng_done = 1'b1;
               tick();
               a_eng_done = 1'b0;
            end
         end
      end
      if (!stop) begin
         check("done_latency", cyc - c0, 61);
         check("run_done", 32'(a_done), 1);
         check("run_err", 32'(a_err), 0);
         check("run_busy", 32'(a_busy), 0);
         check("run_pulses", a_pulses - p0, 5);
         check("run_last_idx", 32'(a_layer_idx), 4);
         check("cfg_held_out_base", a_cfg_out_base, 32'h0);
         check("cfg_held_w_base", a_cfg_w_base, 32'h2840);
         tick();
         check("done_is_level", 32'(a_done), 1);
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      a_start = 1'b0;
      a_eng_done = 1'b0;
      b_start = 1'b0;
      b_eng_done = 1'b0;
      tick();
      tick();
      check("reset_done", 32'(a_done), 0);
      check("reset_err", 32'(a_err), 0);
      check("reset_busy", 32'(a_busy), 0);
      check("reset_eng_start", 32'(a_eng_start), 0);
      check("reset_layer_idx", 32'(a_layer_idx), 0);
      check("reset_cfg_w_base", a_cfg_w_base, 0);
      check("reset_b_status", 32'({b_done, b_err, b_busy, b_eng_start}), 0);
      rst = 1'b0;
      tick();
      check("idle_no_start", 32'(a_busy), 0);

      // Full run from IDLE.
      run_a(1'b0, -1, -1, -1);
      // Restart from DONE with a stray eng_done in every FIRE cycle.
      run_a(1'b1, -1, -1, -1);
      // start pulsed during WAIT of layer 1 is ignored.
      run_a(1'b0, 1, -1, -1);
      // Reset 3 cycles into WAIT of layer 3, then a clean restart at layer 0.
      run_a(1'b0, -1, -1, 3);
      run_a(1'b0, -1, -1, -1);
      // Engine silent on layer 2, then restart out of ERR.
      run_a(1'b0, -1, 2, -1);
      run_a(1'b0, -1, -1, -1);

      // Instance B: eng_done on the last timeout cycle must win.
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      n = 0;
      while (b_eng_start !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("b_eng_start_seen", 32'(b_eng_start), 1);
      for (int k = 0; k < TO_B; k++) tick();
      check("b_last_cycle_no_done", 32'(b_done), 0);
      b_eng_done = 1'b1;
      tick();
      b_eng_done = 1'b0;
      check("b_coincident_err", 32'(b_err), 0);
      check("b_coincident_done", 32'(b_done), 0);
      check("b_coincident_busy", 32'(b_busy), 1);
      check("b_coincident_next_idx", 32'(b_layer_idx), 1);
      tick();
      check("b_next_fire", 32'(b_eng_start), 1);
      // Now let layer 1 time out: still waiting after TO_B edges, ERR on the next.
      for (int k = 0; k < TO_B; k++) tick();
      check("b_wait_full_window", 32'(b_done), 0);
      tick();
      check("b_timeout_done", 32'(b_done), 1);
      check("b_timeout_err", 32'(b_err), 1);
      check("b_timeout_idx", 32'(b_layer_idx), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
